// File: rtl/if_prefetch_unit_if.sv
// Decode-side handshake bundle of the instruction prefetch unit.
// The fetch stage is the master; decode is the slave.
interface if_prefetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc4;

  modport master (
    output out_valid,
    output out_inst,
    output out_pc,
    output out_pc4,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_inst,
    input  out_pc,
    input  out_pc4,
    output out_ready
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// RV32 instruction-fetch stage: PC ownership, unified-port fetch with stall,
// prefetch FIFO toward decode, and flush-and-redirect on taken control flow.
module if_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     ADDR_W   = 8,
  parameter int unsigned     STALL_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       mem_busy,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [STALL_W-1:0]         stall_cnt,
  if_prefetch_unit_if.master         dec
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  entry_t             fifo_mem [DEPTH];
  entry_t             head_c;
  logic [XLEN-1:0]    pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [STALL_W-1:0] stall_q;
  logic               err_q;
  logic               valid_c;
  logic               full_c;
  logic               pop_c;
  logic               push_c;

  assign valid_c = (count != '0);
  assign full_c  = (count == CNT_W'(DEPTH));
  assign pop_c   = valid_c && dec.out_ready;
  // A full FIFO still accepts a fetch when the head leaves in the same cycle.
  assign push_c  = !redirect && !mem_busy && (!full_c || pop_c);

  // PC, FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (redirect) begin
      pc     <= {redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        fifo_mem[wr_ptr] <= {pc, imem_rdata};
        wr_ptr           <= wr_ptr + PTR_W'(1);
        pc               <= pc + XLEN'(4);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count <= count + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Saturating count of fetch cycles lost to data accesses on the shared port.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (mem_busy && !redirect && !full_c && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      err_q <= 1'b1;
    end
  end

  assign head_c        = fifo_mem[rd_ptr];
  assign imem_addr     = pc[ADDR_W+1:2];
  assign misalign_err  = err_q;
  assign fifo_count    = count;
  assign stall_cnt     = stall_q;

  assign dec.out_valid = valid_c;
  assign dec.out_inst  = head_c.inst;
  assign dec.out_pc    = head_c.pc;
  // Forced to zero while empty so a cleared FIFO presents an all-zero head.
  assign dec.out_pc4   = valid_c ? (head_c.pc + XLEN'(4)) : '0;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized plus directed bench for if_prefetch_unit against a queue-based
// reference model of the fetch stage.
module tb_if_prefetch_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned STALL_W  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          MAX_STALL = (1 << STALL_W) - 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic                   clk;
  logic                   rst;
  logic [ADDR_W-1:0]      imem_addr;
  logic [31:0]            imem_rdata;
  logic                   mem_busy;
  logic                   redirect;
  logic [XLEN-1:0]        redirect_pc;
  logic                   misalign_err;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [STALL_W-1:0]     stall_cnt;

  logic [31:0] mem_tb [256];

  if_prefetch_unit_if #(.XLEN(XLEN)) dec_if ();

  if_prefetch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH),
    .ADDR_W(ADDR_W), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .mem_busy(mem_busy), .redirect(redirect), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err), .fifo_count(fifo_count),
    .stall_cnt(stall_cnt), .dec(dec_if)
  );

  assign imem_rdata = mem_tb[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  ent_t        q[$];
  logic [31:0] mpc;
  bit          merr;
  int          mstall;
  bit          zero_head;
  bit          known;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    if (!known) return;
    check_eq("out_valid",    32'(dec_if.out_valid), 32'(q.size() != 0));
    check_eq("fifo_count",   32'(fifo_count),       32'(q.size()));
    check_eq("imem_addr",    32'(imem_addr),        32'(mpc[9:2]));
    check_eq("misalign_err", 32'(misalign_err),     32'(merr));
    check_eq("stall_cnt",    32'(stall_cnt),        32'(mstall));
    if (q.size() != 0) begin
      check_eq("out_inst", dec_if.out_inst, q[0].inst);
      check_eq("out_pc",   dec_if.out_pc,   q[0].pc);
      check_eq("out_pc4",  dec_if.out_pc4,  q[0].pc + 32'd4);
    end else if (zero_head) begin
      check_eq("rst_out_inst", dec_if.out_inst, 32'h0);
      check_eq("rst_out_pc",   dec_if.out_pc,   32'h0);
      check_eq("rst_out_pc4",  dec_if.out_pc4,  32'h0);
    end
  endtask

  task automatic model_step(input bit r, input bit b, input bit rd,
                            input logic [31:0] rpc, input bit rdy);
    bit full;
    bit pop;
    bit fetch;
    if (r) begin
      q.delete();
      mpc       = RESET_PC;
      merr      = 0;
      mstall    = 0;
      zero_head = 1;
      known     = 1;
    end else if (rd) begin
      q.delete();
      mpc       = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) merr = 1;
      zero_head = 0;
    end else begin
      full  = (q.size() == DEPTH);
      pop   = (q.size() != 0) && rdy;
      fetch = !b && (!full || pop);
      if (b && !full && mstall < MAX_STALL) mstall++;
      if (pop) void'(q.pop_front());
      if (fetch) begin
        q.push_back('{pc: mpc, inst: mem_tb[mpc[9:2]]});
        mpc       = mpc + 32'd4;
        zero_head = 0;
      end
    end
  endtask

  // Check the state left by the previous edge, then apply this cycle's inputs.
  task automatic cycle(input bit r, input bit b, input bit rd,
                       input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    compare_outputs();
    rst              = r;
    mem_busy         = b;
    redirect         = rd;
    redirect_pc      = rpc;
    dec_if.out_ready = rdy;
    model_step(r, b, rd, rpc, rdy);
  endtask

  task automatic run(input int n, input bit b, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, b, 0, 32'h0, rdy);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    known    = 0;
    for (int k = 0; k < 256; k++) mem_tb[k] = 32'h0000_0013 + 32'(k);
    rst = 1; mem_busy = 0; redirect = 0; redirect_pc = '0; dec_if.out_ready = 1;

    // Reset and stream
    cycle(1, 0, 0, 32'h0, 1);
    cycle(1, 0, 0, 32'h0, 1);
    run(8, 0, 1);

    // Backpressure fill from a fresh reset, then release
    cycle(1, 0, 0, 32'h0, 0);
    cycle(1, 0, 0, 32'h0, 0);
    run(10, 0, 0);
    run(8, 0, 1);

    // mem_busy while streaming
    run(3, 1, 1);
    run(5, 0, 1);

    // Redirect while full, with a pop in the same cycle
    run(6, 0, 0);
    cycle(0, 0, 1, 32'h40, 1);
    run(4, 0, 1);

    // Misaligned redirect, then an aligned one: flag stays sticky
    cycle(0, 0, 1, 32'h42, 1);
    run(3, 0, 1);
    cycle(0, 1, 1, 32'h80, 1);
    run(3, 0, 1);

    // PC wrap at the top of the address space
    cycle(0, 0, 1, 32'hFFFF_FFF8, 1);
    run(4, 0, 1);

    // Stall counter saturation, then reset while full with everything asserted
    cycle(1, 0, 0, 32'h0, 1);
    run(6, 1, 1);
    run(6, 0, 0);
    cycle(1, 1, 1, 32'h123, 1);
    run(2, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit          r;
      bit          b;
      bit          rd;
      bit          rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) == 0);
      b   = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 1023));
      cycle(r, b, rd, rpc, rdy);
    end

    @(negedge clk);
    compare_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
